// File: rtl/fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// fetch_decode_queue
//
// Instruction buffer between the fetch and decode stages. Each fetched packet
// {pc, instruction, pred_taken, pred_target} is captured into a circular
// buffer and presented to decode in strict arrival order. The buffer lets
// fetch keep running while decode stalls. A controller flush discards every
// packet in flight.
//
// Ports
//   clk              system clock, all state updates on the rising edge
//   rst              synchronous reset, active-high (priority over flush)
//   flush            controller flush (mispredict / irregular PC)
//   in_valid         fetch presents a packet
//   in_ready         queue can accept a packet (registered state only)
//   in_pc            PC of the fetched instruction
//   in_instruction   fetched instruction word
//   in_pred_taken    branch predicted taken
//   in_pred_target   predicted branch target
//   out_valid        head packet available to decode
//   out_ready        decode consumes the head this cycle
//   out_pc           head PC (zero when out_valid is low)
//   out_instruction  head instruction (zero when out_valid is low)
//   out_pred_taken   head prediction (zero when out_valid is low)
//   out_pred_target  head predicted target (zero when out_valid is low)
//   count            number of occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_decode_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_WIDTH-1:0]        in_pc,
  input  logic [INSN_WIDTH-1:0]        in_instruction,
  input  logic                         in_pred_taken,
  input  logic [ADDR_WIDTH-1:0]        in_pred_target,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [INSN_WIDTH-1:0]        out_instruction,
  output logic                         out_pred_taken,
  output logic [ADDR_WIDTH-1:0]        out_pred_target,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Payload storage. Contents are never cleared; occupancy is tracked by
  // count_q alone, so stale data is unreachable after flush or reset.
  logic [ADDR_WIDTH-1:0] pc_mem     [DEPTH];
  logic [INSN_WIDTH-1:0] insn_mem   [DEPTH];
  logic                  taken_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] target_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic push;
  logic pop;

  // Handshake flags come from registered state only; in particular in_ready
  // ignores out_ready, so a full queue never accepts a pass-through push.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid  & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // Pointers, occupancy and payload. Reset and flush share the same effect;
  // either one discards the push/pop of that cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]     <= in_pc;
        insn_mem[wr_ptr]   <= in_instruction;
        taken_mem[wr_ptr]  <= in_pred_taken;
        target_mem[wr_ptr] <= in_pred_target;
        wr_ptr             <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head presentation: decode sees an all-zero NOP bubble when empty.
  always_comb begin
    out_pc          = '0;
    out_instruction = '0;
    out_pred_taken  = 1'b0;
    out_pred_target = '0;
    if (out_valid) begin
      out_pc          = pc_mem[rd_ptr];
      out_instruction = insn_mem[rd_ptr];
      out_pred_taken  = taken_mem[rd_ptr];
      out_pred_target = target_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_queue
//
// Directed stimulus drives the fetch side and decode-ready. A scoreboard
// queue records every accepted packet; a monitor on the falling edge pops and
// compares whenever decode consumes the head, and tracks occupancy.
// ---------------------------------------------------------------------------
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] insn;
    logic          taken;
    logic [AW-1:0] target;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_pred_taken;
  logic [AW-1:0] in_pc, in_pred_target;
  logic [IW-1:0] in_instruction;
  logic          out_valid, out_ready, out_pred_taken;
  logic [AW-1:0] out_pc, out_pred_target;
  logic [IW-1:0] out_instruction;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;
  pkt_t exp_q[$];

  fetch_decode_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSN_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instruction(in_instruction),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instruction(out_instruction),
    .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard. Sampled mid-cycle, so it sees exactly what the next
  // rising edge will act on.
  always @(negedge clk) begin
    pkt_t e;
    if (!rst) begin
      chk("mon_count", 64'(count), 64'(exp_q.size()));
      if (!out_valid) begin
        chk("bubble_pc", 64'(out_pc), 64'd0);
        chk("bubble_insn", 64'(out_instruction), 64'd0);
        chk("bubble_pred", 64'({out_pred_taken, out_pred_target}), 64'd0);
      end
    end
    if (!rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected_pc", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", 64'(out_pc), 64'(e.pc));
        chk("pop_insn", 64'(out_instruction), 64'(e.insn));
        chk("pop_taken", 64'(out_pred_taken), 64'(e.taken));
        chk("pop_target", 64'(out_pred_target), 64'(e.target));
      end
    end
    if (rst || flush) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back('{pc: in_pc, insn: in_instruction, taken: in_pred_taken,
                        target: in_pred_target});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] pc,
                       input logic tk = 1'b0, input logic [AW-1:0] tg = '0);
    in_valid       = v;
    in_pc          = pc;
    in_instruction = 32'h0000_0013 + pc;
    in_pred_taken  = tk;
    in_pred_target = tg;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_out_pc"}, 64'(out_pc), 64'd0);
  endtask

  // Drain with out_ready high under a cycle budget.
  task automatic drain(input string tag);
    int budget = 20;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (count != 0 && budget > 0) begin
      cyc();
      budget--;
    end
    chk({tag, "_drained"}, 64'(count), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    cyc(2);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      idle_checks("s1");
      cyc();
    end

    // 2: fill to full, fifth push held off, then ordered drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(4 * i));
      cyc();
    end
    chk("s2_full_count", 64'(count), 64'd4);
    chk("s2_full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h10);
    cyc(2);
    chk("s2_held_count", 64'(count), 64'd4);
    chk("s2_head_pc", 64'(out_pc), 64'h0);
    drive(1'b0, '0);
    out_ready = 1'b1;
    cyc(4);
    chk("s2_empty_count", 64'(count), 64'd0);
    out_ready = 1'b0;

    // 3: streaming through an initially empty queue
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h1000 + AW'(4 * i));
      cyc();
      chk("s3_out_valid", 64'(out_valid), 64'd1);
      chk("s3_count", 64'(count), 64'd1);
      chk("s3_head_pc", 64'(out_pc), 64'(32'h1000 + 4 * i));
    end
    drain("s3");

    // 4: flush with a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + AW'(4 * i));
      cyc();
    end
    chk("s4_pre_count", 64'(count), 64'd3);
    flush = 1'b1;
    drive(1'b1, 32'h100);
    cyc();
    flush = 1'b0;
    chk("s4_flush_count", 64'(count), 64'd0);
    chk("s4_flush_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h200);
    cyc();
    drive(1'b0, '0);
    chk("s4_head_valid", 64'(out_valid), 64'd1);
    chk("s4_head_pc", 64'(out_pc), 64'h200);
    chk("s4_head_count", 64'(count), 64'd1);
    drain("s4");

    // 5: prediction bits travel with their packet
    drive(1'b1, 32'h300);
    cyc();
    drive(1'b1, 32'h304, 1'b1, 32'h80);
    cyc();
    drive(1'b1, 32'h308);
    cyc();
    drive(1'b0, '0);
    out_ready = 1'b1;
    cyc();
    chk("s5_mid_pc", 64'(out_pc), 64'h304);
    chk("s5_mid_taken", 64'(out_pred_taken), 64'd1);
    chk("s5_mid_target", 64'(out_pred_target), 64'h80);
    cyc();
    chk("s5_last_taken", 64'(out_pred_taken), 64'd0);
    drain("s5");

    // 6: reset during a simultaneous push/pop at count=2
    drive(1'b1, 32'h500);
    cyc();
    drive(1'b1, 32'h504);
    cyc();
    chk("s6_pre_count", 64'(count), 64'd2);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h508);
    cyc();
    rst = 1'b0;
    drive(1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      idle_checks("s6");
      cyc();
    end
    drive(1'b1, 32'h600);
    cyc();
    drive(1'b0, '0);
    chk("s6_new_head_pc", 64'(out_pc), 64'h600);
    drain("s6");
    cyc(3);

    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
